// File: rtl/ccsds_iq_axis_packer.sv
// ccsds_iq_axis_packer
//   Buffers I/Q sample pairs from the CCSDS modulator in a small FIFO and packs
//   each pair into one 32-bit AXI4-Stream beat: {I lane, Q lane}. Each 16-bit
//   lane is {mark[1:0], sample, zero pad}. Beats are grouped into frames of
//   FRAME_LEN beats, and TLAST marks the final beat of each frame.
//
//   A pair that arrives while the FIFO is full and no beat is leaving is
//   dropped. The drop sets the sticky overflow_o flag.
//
//   Optional build macro: CCSDS_IQ_IDLE_FILL_EN
//     defined   - when the FIFO is empty the stream carries fill beats
//                 {I_MARK, 14'b0, Q_MARK, 14'b0}. These count toward framing.
//     undefined - TVALID simply follows FIFO non-empty.
//
//   level_o counts every pair held by the block. This includes the one
//   currently presented on TDATA. It never includes a fill beat.
module ccsds_iq_axis_packer #(
  parameter int          SAMPLE_W   = 13,
  parameter int          FIFO_DEPTH = 8,
  parameter int          FRAME_LEN  = 256,
  parameter logic [1:0]  I_MARK     = 2'b10,
  parameter logic [1:0]  Q_MARK     = 2'b01
) (
  input  logic                          M_AXIS_ACLK,
  input  logic                          M_AXIS_ARESETN,
  input  logic [SAMPLE_W-1:0]           i_data_i,
  input  logic [SAMPLE_W-1:0]           q_data_i,
  input  logic                          valid_i,
  input  logic                          ovf_clr_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          M_AXIS_TVALID,
  output logic [31:0]                   M_AXIS_TDATA,
  output logic [3:0]                    M_AXIS_TSTRB,
  output logic                          M_AXIS_TLAST,
  input  logic                          M_AXIS_TREADY
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(FRAME_LEN - 1);
  localparam logic [LW-1:0]    DEPTH_LVL  = LW'(FIFO_DEPTH);
  localparam logic [3:0]       LANE_MARKS = {I_MARK, Q_MARK};
  localparam logic [31:0]      FILL_WORD  = {I_MARK, 14'b0, Q_MARK, 14'b0};

  // Packed beat for the incoming pair. Lane 1 is I (upper half), lane 0 is Q.
  logic [31:0] din;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [SAMPLE_W-1:0] sample;
      assign sample = (gi == 1) ? i_data_i : q_data_i;
      // The sample is left-justified in 14 bits, so narrow samples are zero-padded below.
      assign din[gi*16 +: 16] = {LANE_MARKS[gi*2 +: 2], 14'(sample) << (14 - SAMPLE_W)};
    end
  endgenerate

  // FIFO storage and state
  logic [31:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    count_reg, count_next;

  // Output beat register
  logic             tvalid_reg, tvalid_next;
  logic [31:0]      tdata_reg, tdata_next;
  logic             tlast_reg, tlast_next;
  logic             fill_reg, fill_next;     // presented beat is a fill word

  logic [CNT_W-1:0] beat_reg, beat_next;
  logic             ovf_reg, ovf_next;

  logic             handshake;
  logic             fifo_pop;
  logic             full;
  logic             push;
  logic             drop;
  logic             slot_free;
  logic [31:0]      head_word;

  // Next-state logic: FIFO bookkeeping, output beat selection and framing
  always_comb begin
    handshake = tvalid_reg && M_AXIS_TREADY;
    // An accepted fill beat does not consume a FIFO entry.
    fifo_pop  = handshake && !fill_reg;
    full      = (count_reg == DEPTH_LVL);
    push      = valid_i && (!full || fifo_pop);
    drop      = valid_i && !push;

    wr_ptr_next = push     ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    rd_ptr_next = fifo_pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    count_next  = count_reg + LW'(push) - LW'(fifo_pop);

    // The new head entry is the one being written this cycle only when no
    // older entry is left after the pop. Bypass the array in that case.
    if (push && (count_reg == LW'(fifo_pop))) begin
      head_word = din;
    end else begin
      head_word = mem[rd_ptr_next];
    end

    // The output slot may change only when it is empty or being accepted.
    // This keeps a stalled beat stable.
    slot_free   = !tvalid_reg || M_AXIS_TREADY;
    tvalid_next = tvalid_reg;
    tdata_next  = tdata_reg;
    fill_next   = fill_reg;
    if (slot_free) begin
      if (count_next != '0) begin
        tvalid_next = 1'b1;
        tdata_next  = head_word;
        fill_next   = 1'b0;
      end else begin
`ifdef CCSDS_IQ_IDLE_FILL_EN
        tvalid_next = 1'b1;
        tdata_next  = FILL_WORD;
        fill_next   = 1'b1;
`else
        tvalid_next = 1'b0;
        fill_next   = 1'b0;
`endif
      end
    end

    // The beat counter advances only on a handshake, so it holds through starvation.
    if (handshake) begin
      beat_next = (beat_reg == LAST_BEAT) ? '0 : beat_reg + 1'b1;
    end else begin
      beat_next = beat_reg;
    end
    tlast_next = tvalid_next && (beat_next == LAST_BEAT);

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop) begin
      ovf_next = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_next = 1'b0;
    end else begin
      ovf_next = ovf_reg;
    end
  end

  // FIFO array write (no reset, so it can map to distributed/block RAM)
  always_ff @(posedge M_AXIS_ACLK) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      fill_reg   <= 1'b0;
      beat_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      tvalid_reg <= tvalid_next;
      tdata_reg  <= tdata_next;
      tlast_reg  <= tlast_next;
      fill_reg   <= fill_next;
      beat_reg   <= beat_next;
      ovf_reg    <= ovf_next;
    end
  end

  assign overflow_o    = ovf_reg;
  assign level_o       = count_reg;
  assign M_AXIS_TVALID = tvalid_reg;
  assign M_AXIS_TDATA  = tdata_reg;
  assign M_AXIS_TSTRB  = 4'hF;
  assign M_AXIS_TLAST  = tlast_reg;

endmodule

// File: tb/tb_ccsds_iq_axis_packer.sv
// Testbench for ccsds_iq_axis_packer (SAMPLE_W=13, FIFO_DEPTH=8, FRAME_LEN=4).
// Each table row gives the inputs for one clock edge and the outputs expected
// just after that edge. A hand-written step checks that an asynchronous
// reset asserted mid-stream takes effect immediately.
module tb_ccsds_iq_axis_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] i_data = '0;
  logic [12:0] q_data = '0;
  logic        valid = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        overflow;
  logic [3:0]  level;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ccsds_iq_axis_packer #(
    .SAMPLE_W   (13),
    .FIFO_DEPTH (8),
    .FRAME_LEN  (4),
    .I_MARK     (2'b10),
    .Q_MARK     (2'b01)
  ) dut (
    .M_AXIS_ACLK    (clk),
    .M_AXIS_ARESETN (rst_n),
    .i_data_i       (i_data),
    .q_data_i       (q_data),
    .valid_i        (valid),
    .ovf_clr_i      (ovf_clr),
    .overflow_o     (overflow),
    .level_o        (level),
    .M_AXIS_TVALID  (tvalid),
    .M_AXIS_TDATA   (tdata),
    .M_AXIS_TSTRB   (tstrb),
    .M_AXIS_TLAST   (tlast),
    .M_AXIS_TREADY  (tready)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    logic [12:0] k;       // sample value used for both I and Q
    logic        ready;
    logic        clr;
    logic        e_tvalid;
    logic [31:0] e_tdata; // compared only when e_tvalid=1
    logic        e_tlast;
    logic [3:0]  e_level;
    logic        e_ovf;
  } vec_t;

  vec_t tbl[$];
  int   split;

  function automatic void add(input logic rst, input logic v, input int k, input logic rdy,
                              input logic clr, input logic etv, input logic [31:0] etd,
                              input logic etl, input int elv, input logic eovf);
    vec_t r;
    r = '{rst, v, 13'(k), rdy, clr, etv, etd, etl, 4'(elv), eovf};
    tbl.push_back(r);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  task automatic run_row(input int idx);
    vec_t r;
    r = tbl[idx];
    rst_n   = !r.rst;
    valid   = r.valid;
    i_data  = r.k;
    q_data  = r.k;
    tready  = r.ready;
    ovf_clr = r.clr;
    @(posedge clk);
    #1;
    chk("tvalid", idx, 32'(tvalid), 32'(r.e_tvalid));
    if (r.e_tvalid) chk("tdata", idx, tdata, r.e_tdata);
    chk("tlast", idx, 32'(tlast), 32'(r.e_tlast));
    chk("level", idx, 32'(level), 32'(r.e_level));
    chk("overflow", idx, 32'(overflow), 32'(r.e_ovf));
    chk("tstrb", idx, 32'(tstrb), 32'h0000_000F);
    $display("step=%0d rst=%0d v=%0d k=%0d rdy=%0d clr=%0d -> tv=%0d td=%h tl=%0d lvl=%0d ovf=%0d",
             idx, r.rst, r.valid, r.k, r.ready, r.clr, tvalid, tdata, tlast, level, overflow);
  endtask

  initial begin
`ifdef CCSDS_IQ_IDLE_FILL_EN
    // Idle fill: continuous fill beats, TLAST on every 4th accepted beat
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,1,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,1,0,0);
    // A pair arriving during a stalled fill beat waits behind it
    add(0,1,1,0,0, 1,32'h8000_4000,1,1,0);
    add(0,0,0,1,0, 1,32'h8002_4002,0,1,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
    split = tbl.size();
    add(1,0,0,1,0, 0,32'h0,0,0,0);
    add(0,0,0,1,0, 1,32'h8000_4000,0,0,0);
`else
    // T1: fill five entries while stalled, then drain
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,0,0, 1,32'h8000_4000,0,1,0);
    add(0,1,1,0,0, 1,32'h8000_4000,0,2,0);
    add(0,1,2,0,0, 1,32'h8000_4000,0,3,0);
    add(0,1,3,0,0, 1,32'h8000_4000,0,4,0);
    add(0,1,4,0,0, 1,32'h8000_4000,0,5,0);
    add(0,0,0,1,0, 1,32'h8002_4002,0,4,0);
    add(0,0,0,1,0, 1,32'h8004_4004,0,3,0);
    add(0,0,0,1,0, 1,32'h8006_4006,1,2,0);
    add(0,0,0,1,0, 1,32'h8008_4008,0,1,0);
    add(0,0,0,1,0, 0,32'h0,0,0,0);
    // T2: overflow on the 9th push, then clear
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,0,0, 1,32'h8000_4000,0,1,0);
    add(0,1,1,0,0, 1,32'h8000_4000,0,2,0);
    add(0,1,2,0,0, 1,32'h8000_4000,0,3,0);
    add(0,1,3,0,0, 1,32'h8000_4000,0,4,0);
    add(0,1,4,0,0, 1,32'h8000_4000,0,5,0);
    add(0,1,5,0,0, 1,32'h8000_4000,0,6,0);
    add(0,1,6,0,0, 1,32'h8000_4000,0,7,0);
    add(0,1,7,0,0, 1,32'h8000_4000,0,8,0);
    add(0,1,8,0,0, 1,32'h8000_4000,0,8,1);
    add(0,0,0,0,1, 1,32'h8000_4000,0,8,0);
    // T3: push+pop while full, then drain; pair 8 never appears
    add(0,1,9,1,0, 1,32'h8002_4002,0,8,0);
    add(0,0,0,1,0, 1,32'h8004_4004,0,7,0);
    add(0,0,0,1,0, 1,32'h8006_4006,1,6,0);
    add(0,0,0,1,0, 1,32'h8008_4008,0,5,0);
    add(0,0,0,1,0, 1,32'h800A_400A,0,4,0);
    add(0,0,0,1,0, 1,32'h800C_400C,0,3,0);
    add(0,0,0,1,0, 1,32'h800E_400E,1,2,0);
    add(0,0,0,1,0, 1,32'h8012_4012,0,1,0);
    add(0,0,0,1,0, 0,32'h0,0,0,0);
    // T4: continuous flow of 10 pairs, TLAST on beats 3 and 7
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,1,0, 1,32'h8000_4000,0,1,0);
    add(0,1,1,1,0, 1,32'h8002_4002,0,1,0);
    add(0,1,2,1,0, 1,32'h8004_4004,0,1,0);
    add(0,1,3,1,0, 1,32'h8006_4006,1,1,0);
    add(0,1,4,1,0, 1,32'h8008_4008,0,1,0);
    add(0,1,5,1,0, 1,32'h800A_400A,0,1,0);
    add(0,1,6,1,0, 1,32'h800C_400C,0,1,0);
    add(0,1,7,1,0, 1,32'h800E_400E,1,1,0);
    add(0,1,8,1,0, 1,32'h8010_4010,0,1,0);
    add(0,1,9,1,0, 1,32'h8012_4012,0,1,0);
    add(0,0,0,1,0, 0,32'h0,0,0,0);
    // Starved with counter at 2: the next beat is 2, and the one after carries TLAST
    add(0,1,10,1,0, 1,32'h8014_4014,0,1,0);
    add(0,1,11,1,0, 1,32'h8016_4016,1,1,0);
    add(0,0,0,1,0, 0,32'h0,0,0,0);
    // T5: reach a TLAST beat, then stall it for 5 cycles
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,0,1,0, 1,32'h8000_4000,0,1,0);
    add(0,1,1,1,0, 1,32'h8002_4002,0,1,0);
    add(0,1,2,1,0, 1,32'h8004_4004,0,1,0);
    add(0,1,3,1,0, 1,32'h8006_4006,1,1,0);
    add(0,1,4,0,0, 1,32'h8006_4006,1,2,0);
    for (int s = 0; s < 5; s++) add(0,0,0,0,0, 1,32'h8006_4006,1,2,0);
    split = tbl.size();
    // After the mid-stream reset, framing restarts at beat 0
    add(1,0,0,0,0, 0,32'h0,0,0,0);
    add(0,1,5,0,0, 1,32'h800A_400A,0,1,0);
    add(0,1,6,1,0, 1,32'h800C_400C,0,1,0);
    add(0,1,7,1,0, 1,32'h800E_400E,0,1,0);
    add(0,1,8,1,0, 1,32'h8010_4010,1,1,0);
    add(0,0,0,1,0, 0,32'h0,0,0,0);
`endif

    for (int n = 0; n < split; n++) run_row(n);

    // Asynchronous reset asserted between edges: outputs clear at once
    rst_n = 1'b0;
    valid = 1'b0;
    #2;
    chk("async_rst_tvalid", split, 32'(tvalid), 32'h0);
    chk("async_rst_level", split, 32'(level), 32'h0);
    chk("async_rst_tlast", split, 32'(tlast), 32'h0);
    chk("async_rst_tdata", split, tdata, 32'h0);
    $display("step=%0d async reset -> tv=%0d tl=%0d lvl=%0d td=%h", split, tvalid, tlast, level, tdata);

    for (int n = split; n < tbl.size(); n++) run_row(n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
